// File: rtl/stream_dw_downsizer_blk_if.sv
// Valid/ready stream bundle shared by the wide input and narrow output sides of the downsizer.
// last is only meaningful on the narrow side; the wide side leaves it unused.
interface stream_dw_downsizer_blk_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/stream_dw_downsizer_blk.sv
// Splits each wide input word into IW/OW narrow beats, frames every BLOCK_BEATS beats with last
// and counts completed blocks.
module stream_dw_downsizer_blk #(
    parameter int unsigned IW          = 32,
    parameter int unsigned OW          = 8,
    parameter bit          MSB_FIRST   = 1'b0,
    parameter int unsigned BLOCK_BEATS = 512,
    parameter int unsigned CW          = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             clr,
    stream_dw_downsizer_blk_if.slave         stream_s,
    stream_dw_downsizer_blk_if.master        stream_m,
    output logic [CW-1:0]                    blk_cnt_o,
    output logic                             busy_o
);
    localparam int unsigned R   = IW / OW;
    localparam int unsigned BW  = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned BBW = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
    localparam logic [BW-1:0]  LastIdx  = BW'(R - 1);
    localparam logic [BBW-1:0] LastBeat = BBW'(BLOCK_BEATS - 1);

    if ((IW % OW) != 0 || R < 2) begin : g_bad_ratio
        $error("IW must be an integer multiple of OW with a ratio of at least 2");
    end
    if (BLOCK_BEATS < 1) begin : g_bad_block
        $error("BLOCK_BEATS must be at least 1");
    end

    typedef enum logic {StEmpty, StShift} state_e;

    state_e         state_q;
    logic [IW-1:0]  shift_q;
    logic [BW-1:0]  beat_idx_q;
    logic [BBW-1:0] blk_beat_q, blk_beat_d;
    logic [CW-1:0]  blk_cnt_q, blk_cnt_d;
    logic           valid_q, valid_d;
    logic           last_q;
    logic           accept, xfer, clr_ok;

    // Ready on the final beat lets the next word load with no bubble.
    assign stream_s.ready = enable & ((state_q == StEmpty) |
                            ((state_q == StShift) & (beat_idx_q == LastIdx) & stream_m.ready));
    assign accept = stream_s.valid & stream_s.ready;
    assign xfer   = valid_q & stream_m.ready;
    assign clr_ok = clr & (state_q == StEmpty) & ~valid_q;

    always_comb begin
        blk_beat_d = blk_beat_q;
        blk_cnt_d  = blk_cnt_q;
        if (clr_ok) begin
            blk_beat_d = '0;
            blk_cnt_d  = '0;
        end else if (xfer) begin
            if (last_q) begin
                blk_beat_d = '0;
                blk_cnt_d  = blk_cnt_q + 1'b1;
            end else begin
                blk_beat_d = blk_beat_q + 1'b1;
            end
        end

        valid_d = valid_q;
        if (state_q == StEmpty) begin
            if (accept) valid_d = 1'b1;
        end else if (xfer && (beat_idx_q == LastIdx) && !accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            shift_q    <= '0;
            beat_idx_q <= '0;
            blk_beat_q <= '0;
            blk_cnt_q  <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            blk_beat_q <= blk_beat_d;
            blk_cnt_q  <= blk_cnt_d;
            valid_q    <= valid_d;
            // last tracks the beat that will be on the bus next cycle.
            last_q     <= valid_d & (blk_beat_d == LastBeat);
            if (clr_ok) beat_idx_q <= '0;
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        shift_q    <= stream_s.data;
                        beat_idx_q <= '0;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    if (xfer) begin
                        if (beat_idx_q != LastIdx) begin
                            shift_q    <= MSB_FIRST ? (shift_q << OW) : (shift_q >> OW);
                            beat_idx_q <= beat_idx_q + 1'b1;
                        end else if (accept) begin
                            shift_q    <= stream_s.data;
                            beat_idx_q <= '0;
                        end else begin
                            state_q <= StEmpty;
                        end
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign stream_m.data  = MSB_FIRST ? shift_q[IW-1 -: OW] : shift_q[OW-1:0];
    assign stream_m.valid = valid_q;
    assign stream_m.last  = last_q;
    assign blk_cnt_o      = blk_cnt_q;
    assign busy_o         = (state_q == StShift);
endmodule

// File: tb/tb_stream_dw_downsizer_blk.sv
// Directed bench for the stream width downsizer: framing, back-pressure, enable, reset and clr.
module tb_stream_dw_downsizer_blk;
    logic clk = 1'b0;
    logic rst_n;
    logic en0, clr0, en1, clr1;
    logic [31:0] blk_cnt0, blk_cnt1;
    logic busy0, busy1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    stream_dw_downsizer_blk_if #(.W(32)) s0 ();
    stream_dw_downsizer_blk_if #(.W(8))  m0 ();
    stream_dw_downsizer_blk_if #(.W(32)) s1 ();
    stream_dw_downsizer_blk_if #(.W(8))  m1 ();

    stream_dw_downsizer_blk #(.BLOCK_BEATS(6)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .clr(clr0),
        .stream_s(s0), .stream_m(m0), .blk_cnt_o(blk_cnt0), .busy_o(busy0)
    );

    stream_dw_downsizer_blk #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .clr(clr1),
        .stream_s(s1), .stream_m(m1), .blk_cnt_o(blk_cnt1), .busy_o(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input logic [31:0] w);
        s0.valid = 1'b1;
        s0.data  = w;
        step();
        s0.valid = 1'b0;
        repeat (4) step();
    endtask

    logic [31:0] words [3];
    logic [31:0] w;
    logic [7:0]  q [$];
    logic [7:0]  exp_b, hd;
    logic        hold, hl, acc, xf, done;
    int          nacc, mb;

    initial begin
        rst_n = 1'b0;
        en0 = 1'b0; clr0 = 1'b0; en1 = 1'b0; clr1 = 1'b0;
        s0.valid = 1'b0; s0.data = '0; s0.last = 1'b0; m0.ready = 1'b0;
        s1.valid = 1'b0; s1.data = '0; s1.last = 1'b0; m1.ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", m0.valid, 1'b0);
        chk("rst_last", m0.last, 1'b0);
        chk("rst_data", m0.data, 8'h00);
        chk("rst_s_ready", s0.ready, 1'b0);
        chk("rst_blk_cnt", blk_cnt0, 32'd0);
        chk("rst_busy", busy0, 1'b0);
        rst_n = 1'b1;
        step();

        // Three back-to-back words, ready high: 12 beats, two 6-beat blocks.
        words[0] = 32'h4433_2211;
        words[1] = 32'h8877_6655;
        words[2] = 32'hCCBB_AA99;
        m0.ready = 1'b1;
        en0 = 1'b1;
        s0.valid = 1'b1;
        s0.data = words[0];
        #1;
        chk("idle_s_ready", s0.ready, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step();
            exp_b = 8'(8'h11 * (k + 1));
            chk("b2b_data", m0.data, exp_b);
            chk("b2b_valid", m0.valid, 1'b1);
            chk("b2b_last", m0.last, (k == 5 || k == 11));
            chk("b2b_blk_cnt", blk_cnt0, (k < 6) ? 32'd0 : 32'd1);
            chk("b2b_s_ready", s0.ready, (k % 4 == 3));
            chk("b2b_busy", busy0, 1'b1);
            if (k % 4 == 0) begin
                if (k / 4 + 1 < 3) s0.data = words[k / 4 + 1];
                else s0.valid = 1'b0;
            end
        end
        step();
        chk("b2b_end_valid", m0.valid, 1'b0);
        chk("b2b_end_blk_cnt", blk_cnt0, 32'd2);
        chk("b2b_end_busy", busy0, 1'b0);

        // Enable drops after accepting a word: it still drains, next word waits.
        s0.valid = 1'b1;
        s0.data = 32'hDEAD_BEEF;
        step();
        chk("en_b0", m0.data, 8'hEF);
        s0.data = 32'h0403_0201;
        en0 = 1'b0;
        step();
        chk("en_b1", m0.data, 8'hBE);
        step();
        chk("en_b2", m0.data, 8'hAD);
        step();
        chk("en_b3", m0.data, 8'hDE);
        chk("en_b3_s_ready", s0.ready, 1'b0);
        step();
        chk("en_off_valid", m0.valid, 1'b0);
        chk("en_off_s_ready", s0.ready, 1'b0);
        step();
        chk("en_off_valid2", m0.valid, 1'b0);
        en0 = 1'b1;
        #1;
        chk("en_on_s_ready", s0.ready, 1'b1);
        step();
        s0.valid = 1'b0;
        chk("en_r0_data", m0.data, 8'h01);
        chk("en_r0_last", m0.last, 1'b0);
        step();
        chk("en_r1_data", m0.data, 8'h02);
        chk("en_r1_last", m0.last, 1'b1);
        step();
        chk("en_r2_blk_cnt", blk_cnt0, 32'd3);
        chk("en_r2_last", m0.last, 1'b0);
        step();
        step();
        chk("en_end_valid", m0.valid, 1'b0);

        // MSB-first instance.
        en1 = 1'b1;
        m1.ready = 1'b1;
        s1.valid = 1'b1;
        s1.data = 32'hA1B2_C3D4;
        step();
        s1.valid = 1'b0;
        chk("msb_b0", m1.data, 8'hA1);
        step();
        chk("msb_b1", m1.data, 8'hB2);
        step();
        chk("msb_b2", m1.data, 8'hC3);
        step();
        chk("msb_b3", m1.data, 8'hD4);
        chk("msb_b3_valid", m1.valid, 1'b1);
        step();
        chk("msb_end_valid", m1.valid, 1'b0);

        // clr while idle zeroes the block count and beat position.
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        chk("clr_idle_blk_cnt", blk_cnt0, 32'd0);

        // Random back-pressure against a byte queue model.
        nacc = 0;
        mb = 0;
        hold = 1'b0;
        hl = 1'b0;
        hd = '0;
        done = 1'b0;
        s0.valid = 1'b1;
        s0.data = $urandom;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            m0.ready = 1'($urandom_range(0, 1));
            #1;
            if (hold) begin
                chk("stall_valid", m0.valid, 1'b1);
                chk("stall_data", m0.data, hd);
                chk("stall_last", m0.last, hl);
            end
            acc = s0.valid & s0.ready;
            xf = m0.valid & m0.ready;
            if (xf) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    exp_b = q.pop_front();
                    chk("rand_data", m0.data, exp_b);
                end
                chk("rand_last", m0.last, (mb % 6 == 5));
                mb++;
            end
            hold = m0.valid & ~m0.ready;
            hd = m0.data;
            hl = m0.last;
            if (acc) begin
                w = s0.data;
                for (int i = 0; i < 4; i++) q.push_back(w[8*i +: 8]);
                nacc++;
            end
            step();
            if (acc) begin
                if (nacc == 64) s0.valid = 1'b0;
                else s0.data = $urandom;
            end
            done = (nacc == 64) && (q.size() == 0) && !m0.valid;
        end
        chk("rand_completed", done, 1'b1);
        chk("rand_blk_cnt", blk_cnt0, 32'd42);

        // Asynchronous reset while holding a word at beat 2.
        m0.ready = 1'b1;
        s0.valid = 1'b1;
        s0.data = 32'h1122_3344;
        step();
        s0.valid = 1'b0;
        step();
        step();
        chk("pre_rst_busy", busy0, 1'b1);
        chk("pre_rst_data", m0.data, 8'h22);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", m0.valid, 1'b0);
        chk("arst_blk_cnt", blk_cnt0, 32'd0);
        chk("arst_busy", busy0, 1'b0);
        chk("arst_data", m0.data, 8'h00);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", m0.valid, 1'b0);
        step();
        chk("post_rst_valid2", m0.valid, 1'b0);

        // clr while busy is ignored; clr while idle takes effect.
        run_word(32'h0403_0201);
        run_word(32'h0807_0605);
        chk("pre_clr_blk_cnt", blk_cnt0, 32'd1);
        s0.valid = 1'b1;
        s0.data = 32'h0C0B_0A09;
        step();
        s0.valid = 1'b0;
        clr0 = 1'b1;
        chk("clr_busy_state", busy0, 1'b1);
        step();
        clr0 = 1'b0;
        repeat (3) step();
        chk("clr_busy_valid", m0.valid, 1'b0);
        chk("clr_busy_blk_cnt", blk_cnt0, 32'd2);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        chk("clr_idle2_blk_cnt", blk_cnt0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
